// File: rtl/fpu_pkg.sv
// Shared FPU constants: class flags, IEEE single-precision field sizes and
// the normalise/round controller state encoding.
package fpu_pkg;

  localparam logic [1:0] FLAG_INF  = 2'b00;
  localparam logic [1:0] FLAG_INV  = 2'b01;
  localparam logic [1:0] FLAG_ZERO = 2'b10;
  localparam logic [1:0] FLAG_NORM = 2'b11;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over a W-bit word; an all-zero word reports W.
module fp_lzc #(
  parameter int W  = 48,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/norm_round.sv
// FPU normalise / round-to-nearest-even stage feeding the result packer.
// Define FAST_LZC_EN for single-step normalisation via leading-zero count.
module norm_round
  import fpu_pkg::*;
#(
  parameter int MW = 48,
  parameter int EW = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    inv_in,
  input  logic                    s_in,
  input  logic signed [EW-1:0]    e_in,
  input  logic        [MW-1:0]    m_in,
  output logic                    busy,
  output logic                    done,
  output logic                    s,
  output logic        [EXP_W-1:0] e,
  output logic        [FRAC_W-1:0] m,
  output logic        [1:0]       flag
);

  localparam logic signed [EW:0] ONE  = (EW+1)'(1);
  localparam logic signed [EW:0] EMAX = (EW+1)'(2**EXP_W - 1);

  state_t                  state;
  logic        [MW-1:0]    mant;
  logic signed [EW:0]      expo;
  logic                    sticky;
  logic                    inv;
  logic                    special;
  logic                    sgn;

  logic        [MW-1:0]    nxt_mant;
  logic signed [EW:0]      nxt_expo;
  logic                    nxt_sticky;
  logic                    shift_go;

  logic        [FRAC_W-1:0] frac;
  logic                    guard;
  logic                    st_all;
  logic        [FRAC_W:0]  rnd;
  logic signed [EW:0]      expo_r;
  logic        [FRAC_W-1:0] frac_r;
  logic        [1:0]       cls;

  function automatic logic [FRAC_W:0] round_ne(
    input logic [FRAC_W-1:0] f,
    input logic              g,
    input logic              stk
  );
    logic up;
    up = g & (stk | f[0]);
    return {1'b0, f} + {{FRAC_W{1'b0}}, up};
  endfunction

`ifdef FAST_LZC_EN
  localparam int CW = $clog2(MW + 1);
  logic        [CW-1:0] lz;
  logic signed [EW:0]   lz_m1;
  logic signed [EW:0]   room;
  logic signed [EW:0]   amt;

  fp_lzc #(.W(MW), .CW(CW)) u_lzc (
    .value (mant),
    .count (lz)
  );
`endif

  // Specials pass through NORM without shifting, so every op spends >= 2 cycles.
  always_comb begin
    nxt_mant   = mant;
    nxt_expo   = expo;
    nxt_sticky = sticky;
    shift_go   = 1'b0;
`ifdef FAST_LZC_EN
    lz_m1 = $signed({{(EW+1-CW){1'b0}}, lz}) - ONE;
    room  = expo - ONE;
    amt   = (lz_m1 < room) ? lz_m1 : room;
`endif
    if (!special) begin
      if (mant[MW-1]) begin
        nxt_mant   = mant >> 1;
        nxt_expo   = expo + ONE;
        nxt_sticky = sticky | mant[0];
        shift_go   = 1'b1;
      end else if (!mant[MW-2] && (expo > ONE)) begin
`ifdef FAST_LZC_EN
        nxt_mant = mant << amt;
        nxt_expo = expo - amt;
`else
        nxt_mant = mant << 1;
        nxt_expo = expo - ONE;
`endif
        shift_go = 1'b1;
      end
    end
  end

  always_comb begin
    frac   = mant[MW-3 -: FRAC_W];
    guard  = mant[MW-3-FRAC_W];
    st_all = sticky | (|mant[MW-4-FRAC_W:0]);
    rnd    = round_ne(frac, guard, st_all);
    expo_r = rnd[FRAC_W] ? (expo + ONE) : expo;
    frac_r = rnd[FRAC_W] ? '0 : rnd[FRAC_W-1:0];
    if (inv)                              cls = FLAG_INV;
    else if (mant == '0)                  cls = FLAG_ZERO;
    else if (!mant[MW-2] || expo_r < ONE) cls = FLAG_ZERO;
    else if (expo_r >= EMAX)              cls = FLAG_INF;
    else                                  cls = FLAG_NORM;
  end

  // Control and result registers: cleared by reset, which also aborts an op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= 1'b0;
      e     <= '0;
      m     <= '0;
      flag  <= FLAG_INV;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (!shift_go) state <= ST_ROUND;
        end
        ST_ROUND: begin
          s     <= sgn;
          flag  <= cls;
          e     <= (cls == FLAG_NORM) ? expo_r[EXP_W-1:0] : '0;
          m     <= (cls == FLAG_NORM) ? frac_r : '0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Working datapath: no reset, only meaningful while an op is in flight.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (start) begin
        mant    <= m_in;
        expo    <= {e_in[EW-1], e_in};
        sticky  <= 1'b0;
        inv     <= inv_in;
        special <= inv_in | (m_in == '0);
        sgn     <= s_in;
      end
    end else if (state == ST_NORM) begin
      mant   <= nxt_mant;
      expo   <= nxt_expo;
      sticky <= nxt_sticky;
    end
  end

endmodule

// File: tb/tb_norm_round.sv
// Directed self-checking bench for norm_round (default and FAST_LZC_EN builds).
module tb_norm_round;

  localparam int MW    = 48;
  localparam int EW    = 10;
  localparam int LIMIT = 100;

  logic              clk;
  logic              rst;
  logic              start;
  logic              inv_in;
  logic              s_in;
  logic signed [9:0] e_in;
  logic [47:0]       m_in;
  logic              busy;
  logic              done;
  logic              s;
  logic [7:0]        e;
  logic [22:0]       m;
  logic [1:0]        flag;

  int n_checks = 0;
  int n_fail   = 0;

  norm_round #(.MW(MW), .EW(EW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inv_in (inv_in),
    .s_in   (s_in),
    .e_in   (e_in),
    .m_in   (m_in),
    .busy   (busy),
    .done   (done),
    .s      (s),
    .e      (e),
    .m      (m),
    .flag   (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] xp);
    n_checks++;
    assert (obs === xp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, xp);
    end
  endtask

  // Expected latency for N normalisation shifts.
  function automatic int lat_of(input int n);
`ifdef FAST_LZC_EN
    return (n == 0) ? 2 : 3;
`else
    return 2 + n;
`endif
  endfunction

  task automatic run_op(input string tag, input logic iv, input logic sv,
                        input logic signed [9:0] ev, input logic [47:0] mv,
                        input int xl, input logic xs, input logic [7:0] xe,
                        input logic [22:0] xm, input logic [1:0] xf);
    int lat;
    @(negedge clk);
    inv_in = iv; s_in = sv; e_in = ev; m_in = mv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= LIMIT && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk({tag, ".busy_inflight"}, busy, 1);
      if (done) lat = c;
    end
    if (lat == 0) lat = -1;
    chk({tag, ".latency"}, lat, xl);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".s"}, s, xs);
    chk({tag, ".e"}, e, xe);
    chk({tag, ".m"}, m, xm);
    chk({tag, ".flag"}, flag, xf);
  endtask

  initial begin
    int  lat;
    logic saw_done;

    rst = 1'b0; start = 1'b0; inv_in = 1'b0; s_in = 1'b0; e_in = '0; m_in = '0;
    #12;
    chk("reset.s", s, 0);
    chk("reset.e", e, 0);
    chk("reset.m", m, 0);
    chk("reset.flag", flag, 2'b01);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    @(negedge clk); rst = 1'b1;

    run_op("normal",     0, 0, 10'sd127, 48'h4000_0000_0000, lat_of(0),  0, 8'd127, 23'd0, 2'b11);
    run_op("rshift",     0, 0, 10'sd127, 48'h8000_0000_0000, lat_of(1),  0, 8'd128, 23'd0, 2'b11);
    run_op("lshift16",   0, 0, 10'sd140, 48'h0000_4000_0000, lat_of(16), 0, 8'd124, 23'd0, 2'b11);
    run_op("rnd_carry",  0, 0, 10'sd100, 48'h7FFF_FFC0_0000, lat_of(0),  0, 8'd101, 23'd0, 2'b11);
    run_op("tie_even",   0, 0, 10'sd127, 48'h4000_0040_0000, lat_of(0),  0, 8'd127, 23'd0, 2'b11);
    run_op("sticky_rs",  0, 0, 10'sd127, 48'h8000_0080_0001, lat_of(1),  0, 8'd128, 23'd1, 2'b11);
    run_op("ovf_e255",   0, 0, 10'sd255, 48'h4000_0000_0000, lat_of(0),  0, 8'd0,   23'd0, 2'b00);
    run_op("ovf_carry",  0, 1, 10'sd254, 48'h7FFF_FFC0_0000, lat_of(0),  1, 8'd0,   23'd0, 2'b00);
    run_op("denorm",     0, 0, 10'sd10,  48'h0000_0000_0001, lat_of(9),  0, 8'd0,   23'd0, 2'b10);
    run_op("unf_e0",     0, 0, 10'sd0,   48'h4000_0000_0000, lat_of(0),  0, 8'd0,   23'd0, 2'b10);
    run_op("unf_eneg",   0, 1, -10'sd3,  48'h4000_0000_0000, lat_of(0),  1, 8'd0,   23'd0, 2'b10);
    run_op("zero",       0, 1, 10'sd127, 48'h0,              lat_of(0),  1, 8'd0,   23'd0, 2'b10);
    run_op("invalid",    1, 0, 10'sd127, 48'h4000_0000_0000, lat_of(0),  0, 8'd0,   23'd0, 2'b01);
    run_op("tie_odd",    0, 1, 10'sd127, 48'h4000_00C0_0000, lat_of(0),  1, 8'd127, 23'd2, 2'b11);

    // Start while busy: the second request must be ignored.
    @(negedge clk);
    inv_in = 1'b0; s_in = 1'b0; e_in = 10'sd140; m_in = 48'h0000_4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= LIMIT && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        chk("drop.busy", busy, 1);
        inv_in = 1'b1; s_in = 1'b1; m_in = 48'h8000_0000_0000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) lat = c;
    end
    start = 1'b0; inv_in = 1'b0; s_in = 1'b0;
    if (lat == 0) lat = -1;
    chk("drop.latency", lat, lat_of(16));
    chk("drop.s", s, 0);
    chk("drop.e", e, 8'd124);
    chk("drop.flag", flag, 2'b11);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("drop.no_second_op", saw_done, 0);

    // Give the outputs a distinctive value before the abort test.
    run_op("pre_abort",  0, 1, 10'sd127, 48'h4000_00C0_0000, lat_of(0),  1, 8'd127, 23'd2, 2'b11);

    @(negedge clk);
    inv_in = 1'b0; s_in = 1'b0; e_in = 10'sd140; m_in = 48'h0000_4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort.s", s, 0);
    chk("abort.e", e, 0);
    chk("abort.m", m, 0);
    chk("abort.flag", flag, 2'b01);
    chk("abort.busy", busy, 0);
    @(negedge clk); rst = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort.no_done", saw_done, 0);
    chk("abort.flag_held", flag, 2'b01);

    run_op("post_abort", 0, 0, 10'sd127, 48'h8000_0000_0000, lat_of(1),  0, 8'd128, 23'd0, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
